fifo_unpacker: RTL
==================

Name: fifo_unpacker

Overview:
- Read-domain consumer of the 140-bit async_fifo; runs entirely on clk_out.
- Pops one FIFO word at a time and decodes its 12-bit header.
- Serialises the 128-bit payload into OUT_W-bit beats on a valid/ready stream with byte keep, last and channel id.
- Sole driver of the FIFO's fifo_r_enable.

Parameters:
- DW, 140, FIFO word width; fixed at 140 (header 12 + payload 128).
- OUT_W, 32, output beat width in bits; legal values 8, 16, 32, 64, 128.

Ports:
- clk_out  in  1  clock (FIFO read-domain clock)
- rst_n  in  1  synchronous active-low reset, sampled on posedge clk_out
- fifo_empty  in  1  FIFO empty flag
- fifo_r_enable  out  1  FIFO pop request; data returns next cycle
- data_from_fifo  in  DW  FIFO read data, valid the cycle after fifo_r_enable
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream accept
- m_data  out  OUT_W  beat payload; byte 0 is in bits [7:0]
- m_keep  out  OUT_W/8  valid-byte mask for the beat
- m_last  out  1  final beat of the word
- m_ch  out  4  channel id of the current word

Behaviour:
- Word format:
  - [139:136] ch_id.
  - [135:132] nb_m1; valid bytes = nb_m1+1, range 1..16.
  - [131:128] reserved, ignored.
  - [127:0] payload; byte k is in bits [8k+7:8k].
- Beats per word: BPB = OUT_W/8; beats = ceil((nb_m1+1)/BPB). Compute with 5-bit arithmetic, no overflow.
- FSM has three states: IDLE, FETCH, SEND.
- IDLE:
  - fifo_r_enable = !fifo_empty (combinational).
  - If fifo_r_enable is high, go to FETCH.
- FETCH:
  - Capture data_from_fifo into a 140-bit holding register.
  - beat_idx = 0; go to SEND.
  - fifo_r_enable = 0.
- SEND:
  - m_valid = 1.
  - m_data = payload bytes [beat_idx*BPB +: BPB].
  - m_ch = held ch_id.
  - m_last = (beat_idx == beats-1).
  - m_keep is all ones except on the last beat, where it is the low ((nb_m1+1) - beat_idx*BPB) bits.
- Handshake: a beat transfers when m_valid && m_ready.
  - Non-last beat transfers: beat_idx increments.
  - Last beat transfers: fifo_r_enable = !fifo_empty in the same cycle. If it is asserted, go to FETCH; otherwise go to IDLE.
- Steady-state throughput: one FIFO word per beats+1 cycles.
- Outputs are stable while m_valid && !m_ready; m_ready may toggle freely.
- fifo_r_enable is never asserted in FETCH, or in SEND before the last handshake. At most one pop is outstanding; the block never pops while fifo_empty is high.
- Outside SEND: m_valid=0, m_data=0, m_keep=0, m_last=0, m_ch=0.
- Reset:
  - state=IDLE, holding register=0, beat_idx=0.
  - All outputs are 0, including fifo_r_enable.
- Reset mid-operation: the word in flight is discarded, with no partial completion and no m_last. A pop issued in the reset cycle is lost; the FIFO is reset by the same rst_n.
- Header edge cases:
  - nb_m1=0 gives 1 beat with keep=0...01.
  - nb_m1=15 with OUT_W=128 gives 1 beat with keep all ones.

Optional Feature:
- Macro: UNPACK_STATS_EN.
- When defined, add output word_cnt [15:0] and output beat_cnt [15:0].
  - word_cnt increments on each m_last handshake; beat_cnt increments on each beat handshake.
  - Both wrap at 0xFFFF→0 and reset to 0.
- When undefined, these ports and their counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Package fifo_unpacker_pkg:
  - Localparams HDR_CH_MSB=139, HDR_CH_LSB=136, HDR_NB_MSB=135, HDR_NB_LSB=132, PAYLOAD_W=128.
  - typedef enum logic [1:0] {IDLE, FETCH, SEND} unpack_state_t.
  - Function beats_for(nb_m1, bpb).
- Sub-module keep_gen: combinational; maps remaining-byte count to the m_keep mask. Instantiated once.

Test Plan:
- Reset then idle: fifo_empty=1 for 10 cycles -> fifo_r_enable=0, m_valid=0, all outputs 0.
- OUT_W=32, word ch=3, nb_m1=15, payload 0x00112233_44556677_8899AABB_CCDDEEFF, m_ready=1:
  - Beats 0xCCDDEEFF, 0x8899AABB, 0x44556677, 0x00112233.
  - keep=0xF on each; m_last on the 4th beat; m_ch=3.
  - First beat appears 2 cycles after fifo_r_enable.
- nb_m1=5, OUT_W=32 -> 2 beats; keep 0xF then 0x3; m_last on beat 2.
- Backpressure: m_ready=0 for 3 cycles mid-word -> m_data/m_keep/m_last held constant, beat_idx frozen, no pop.
- Back-to-back: two words queued, m_ready=1 -> second fifo_r_enable in the same cycle as the first m_last handshake; exactly one bubble cycle (FETCH) between words.
- Reset asserted during beat 2 of 4 -> next cycle m_valid=0, state IDLE. With UNPACK_STATS_EN defined, word_cnt=0 and beat_cnt=0.

Source files
------------

// File: rtl/fifo_unpacker_pkg.sv
// Shared header field positions, FSM state type and beat-count helper for fifo_unpacker.
package fifo_unpacker_pkg;

  localparam int unsigned HDR_CH_MSB = 139;
  localparam int unsigned HDR_CH_LSB = 136;
  localparam int unsigned HDR_NB_MSB = 135;
  localparam int unsigned HDR_NB_LSB = 132;
  localparam int unsigned PAYLOAD_W  = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } unpack_state_t;

  // ceil((nb_m1+1)/bpb) rewritten as (nb_m1+bpb)/bpb; the sum peaks at 31 so 5 bits suffice
  function automatic logic [4:0] beats_for(input logic [3:0] nb_m1, input logic [4:0] bpb);
    logic [4:0] sum;
    sum = {1'b0, nb_m1} + bpb;
    return sum / bpb;
  endfunction

endpackage

// File: rtl/fifo_unpacker_keep_gen.sv
// Maps the count of bytes still owed by the current word to a beat keep mask.
module fifo_unpacker_keep_gen #(
  parameter int unsigned OUT_W = 32
) (
  input  logic [4:0]         i_rem,
  output logic [OUT_W/8-1:0] o_keep
);

  localparam int unsigned KW = OUT_W / 8;

  // Byte k is valid while more than k bytes remain; saturates to all ones on non-final beats
  always_comb begin
    o_keep = '0;
    for (int unsigned k = 0; k < KW; k++) begin
      o_keep[k] = (i_rem > 5'(k));
    end
  end

endmodule

// File: rtl/fifo_unpacker.sv
// Pops 140-bit FIFO words and serialises their payload into OUT_W-bit valid/ready beats.
// Define UNPACK_STATS_EN to add the word_cnt / beat_cnt handshake counters.
module fifo_unpacker
  import fifo_unpacker_pkg::*;
#(
  parameter int unsigned DW    = 140,
  parameter int unsigned OUT_W = 32
) (
  input  logic               clk_out,
  input  logic               rst_n,
  input  logic               fifo_empty,
  output logic               fifo_r_enable,
  input  logic [DW-1:0]      data_from_fifo,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [OUT_W-1:0]   m_data,
  output logic [OUT_W/8-1:0] m_keep,
  output logic               m_last,
  output logic [3:0]         m_ch
`ifdef UNPACK_STATS_EN
  ,
  output logic [15:0]        word_cnt,
  output logic [15:0]        beat_cnt
`endif
);

  localparam int unsigned BPB  = OUT_W / 8;
  localparam logic [4:0]  BPB5 = 5'(BPB);

  unpack_state_t         r_state;
  unpack_state_t         w_state_nxt;
  logic [DW-1:0]         r_hold;
  logic [4:0]            r_beat_idx;
  logic [4:0]            w_beat_nxt;
  logic                  w_pop;

  logic [3:0]            w_nb_m1;
  logic [4:0]            w_beats;
  logic [4:0]            w_byte_off;
  logic [4:0]            w_rem;
  logic                  w_last;
  logic                  w_send;
  logic                  w_hs;
  logic [PAYLOAD_W-1:0]  w_data_sh;
  logic [OUT_W/8-1:0]    w_keep;
  logic                  w_unused_rsvd;

  assign w_nb_m1       = r_hold[HDR_NB_MSB:HDR_NB_LSB];
  assign w_beats       = beats_for(w_nb_m1, BPB5);
  assign w_byte_off    = r_beat_idx * BPB5;
  assign w_rem         = ({1'b0, w_nb_m1} + 5'd1) - w_byte_off;
  assign w_last        = (r_beat_idx == (w_beats - 5'd1));
  assign w_send        = rst_n && (r_state == SEND);
  assign w_hs          = w_send && m_ready;
  assign w_data_sh     = r_hold[PAYLOAD_W-1:0] >> {w_byte_off, 3'b000};
  assign w_unused_rsvd = ^r_hold[131:128];

  fifo_unpacker_keep_gen #(.OUT_W(OUT_W)) u_keep_gen (
    .i_rem  (w_rem),
    .o_keep (w_keep)
  );

  // Everything the stream shows is zero outside SEND and while reset is held
  assign m_valid       = w_send;
  assign m_data        = w_send ? w_data_sh[OUT_W-1:0] : '0;
  assign m_keep        = w_send ? w_keep : '0;
  assign m_last        = w_send && w_last;
  assign m_ch          = w_send ? r_hold[HDR_CH_MSB:HDR_CH_LSB] : 4'd0;
  assign fifo_r_enable = rst_n && w_pop;

  always_ff @(posedge clk_out) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_hold     <= '0;
      r_beat_idx <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_beat_idx <= w_beat_nxt;
      if (r_state == FETCH) begin
        r_hold <= data_from_fifo;
      end
    end
  end

  // Next pop is only requested from IDLE or on the final beat's handshake
  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat_idx;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        w_pop = !fifo_empty;
        if (w_pop) begin
          w_state_nxt = FETCH;
        end
      end
      FETCH: begin
        w_beat_nxt  = 5'd0;
        w_state_nxt = SEND;
      end
      SEND: begin
        if (w_hs) begin
          if (w_last) begin
            w_pop       = !fifo_empty;
            w_state_nxt = w_pop ? FETCH : IDLE;
          end else begin
            w_beat_nxt = r_beat_idx + 5'd1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

`ifdef UNPACK_STATS_EN
  logic [15:0] r_word_cnt;
  logic [15:0] r_beat_cnt;

  always_ff @(posedge clk_out) begin
    if (!rst_n) begin
      r_word_cnt <= '0;
      r_beat_cnt <= '0;
    end else if (w_hs) begin
      r_beat_cnt <= r_beat_cnt + 16'd1;
      if (w_last) begin
        r_word_cnt <= r_word_cnt + 16'd1;
      end
    end
  end

  assign word_cnt = r_word_cnt;
  assign beat_cnt = r_beat_cnt;
`endif

endmodule
